tx_fifo: RTL and testbench
==========================

Name: tx_fifo

Overview:
- Transmit-side buffer placed directly upstream of the UART transmitter.
- Accepts bytes from the host/bus side and stores them in a circular FIFO.
- Hands bytes one at a time to the transmitter through its write-enable / empty-flag handshake.
- Holds each byte stable until the transmitter has latched it at its start-of-frame, so the host can queue a burst without polling per byte.

Parameters:
- WIDTH_DATA, 8: data word width; must match the transmitter.
- DEPTH_LOG2, 4: log2 of FIFO depth (default depth 16); legal range 1..8.

Ports:
- i_clk  input  1  system clock; everything is on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_we  input  1  host push strobe, one word per cycle.
- i_data  input  WIDTH_DATA  host push data.
- o_full  output  1  FIFO full.
- o_empty  output  1  FIFO empty.
- o_count  output  DEPTH_LOG2+1  number of stored words, 0..2^DEPTH_LOG2.
- i_tx_mty  input  1  transmitter holding-register-empty flag; 1 = ready for a new word.
- o_tx_we  output  1  one-cycle write strobe to the transmitter.
- o_tx_data  output  WIDTH_DATA  word presented to the transmitter, registered.

Behaviour:
- Reset, sampled on a rising edge with i_rst=1:
  - Read and write pointers = 0, o_count = 0, o_empty = 1, o_full = 0.
  - o_tx_we = 0, o_tx_data = all ones, FSM = IDLE.
  - A mid-frame reset drops the pending word. There is no flush handshake to the transmitter.
- Storage: 2^DEPTH_LOG2 x WIDTH_DATA register array. Pointers are DEPTH_LOG2 bits wide and wrap modulo the depth.
- Push:
  - Accepted when i_we=1 and (o_full=0, or a pop occurs in the same cycle).
  - Data is written at wr_ptr, wr_ptr increments.
  - A push to a full FIFO with no simultaneous pop is dropped; contents and pointers are unchanged.
- Pop: happens only on the IDLE -> ISSUE transition. Reads the word at rd_ptr into o_tx_data and increments rd_ptr.
- o_count:
  - +1 on accepted push only.
  - -1 on pop only.
  - Unchanged on push and pop in the same cycle.
  - o_empty = (o_count == 0), o_full = (o_count == 2^DEPTH_LOG2). Both are derived from registered count with no extra latency.
- Data written while empty is poppable on the next cycle, i.e. first-word fall-through latency of 1 clock.
- FSM:
  - IDLE:
    - If o_empty=0 and i_tx_mty=1: pop into o_tx_data and go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - o_tx_we=1 for exactly this one cycle.
    - Go to BUSY.
  - BUSY: wait for i_tx_mty=0. The transmitter's flag is registered, so it falls 1 cycle after the strobe. Then go to HOLD.
  - HOLD:
    - o_tx_data is held unchanged.
    - Wait for i_tx_mty=1, which the transmitter raises at start-of-frame when it latches the data.
    - Then go to IDLE.
- o_tx_data changes only on a pop and is otherwise stable in every state.
- Back-to-back words: the next pop may occur on the first IDLE cycle after HOLD exits, if the FIFO is non-empty.
- A host push into an empty FIFO while the FSM is in BUSY/HOLD simply waits in the FIFO.

Optional Feature:
- Macro: TX_FIFO_OVF_EN.
- Defined:
  - Adds output o_ovf (1 bit), a sticky flag set on any dropped push (i_we=1, full, no pop).
  - Cleared only by i_rst.
- Undefined: the port and logic are absent, and dropped pushes are silent.

Decomposition:
- Shared package holds:
  - the FSM state typedef (IDLE, ISSUE, BUSY, HOLD; 2-bit encoding);
  - the default WIDTH_DATA constant, shared with the transmitter and receiver.
- One natural sub-module is fifo_mem: a synchronous-write, combinational-read register array taking wr_en, wr_addr, wr_data, rd_addr, rd_data.
- Pointer, count and FSM logic stay in tx_fifo.

Test Plan:
- Reset then idle: hold i_rst for 2 cycles, keep i_tx_mty=1 -> o_empty=1, o_count=0, o_tx_we=0, o_tx_data=8'hFF for 20 cycles.
- Single word:
  - Stimulus: push 8'hA5 with the transmitter model dropping i_tx_mty 1 cycle after the strobe and raising it 10 cycles later.
  - Required: o_tx_we pulses exactly once with o_tx_data=8'hA5, held through HOLD; o_count returns to 0.
- Burst ordering: push 8'h01..8'h05 back-to-back -> the transmitter receives 01,02,03,04,05 in order with one o_tx_we per word, and none while i_tx_mty=0.
- Full and drop:
  - Stimulus: hold i_tx_mty=0 and push 17 words (8'h00..8'h10).
  - Required: o_full=1 after 16 pushes, o_count=16, the 17th is dropped (o_ovf=1 when TX_FIFO_OVF_EN is defined), and the drained sequence is 00..0F.
- Simultaneous push/pop at full: fill 16, release i_tx_mty=1, push on the pop cycle -> the push is accepted, o_count stays 16, and pointers wrap correctly over 40 further words.
- Reset mid-operation: assert i_rst while in HOLD with 3 words queued -> the next cycle shows o_count=0, FSM IDLE, o_tx_we=0, o_tx_data=8'hFF, and no further strobes.

Source files
------------

// File: rtl/tx_fifo_pkg.sv
`default_nettype none
// =============================================================================
// tx_fifo_pkg : shared UART-path constants and the transmit-FIFO FSM states
// Rev 1.0
// =============================================================================
package tx_fifo_pkg;

    localparam int c_WIDTH_DATA = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_HOLD  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/tx_fifo_mem.sv
`default_nettype none
// =============================================================================
// tx_fifo_mem : synchronous-write, combinational-read register array
// Rev 1.0
// =============================================================================
module tx_fifo_mem #(
    parameter int WIDTH_DATA = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [WIDTH_DATA-1:0] i_wr_data,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [WIDTH_DATA-1:0] o_rd_data
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH_DATA-1:0] r_mem [0:c_DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// =============================================================================
// tx_fifo : transmit FIFO feeding the UART transmitter via we / holding-empty
//           handshake. Optional TX_FIFO_OVF_EN adds sticky overflow flag o_ovf.
// Rev 1.0
// =============================================================================
module tx_fifo
    import tx_fifo_pkg::*;
#(
    parameter int WIDTH_DATA = c_WIDTH_DATA,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [WIDTH_DATA-1:0] i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    input  logic                  i_tx_mty,
    output logic                  o_tx_we,
    output logic [WIDTH_DATA-1:0] o_tx_data
`ifdef TX_FIFO_OVF_EN
    ,
    output logic                  o_ovf
`endif
);

    localparam logic [DEPTH_LOG2:0] c_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [WIDTH_DATA-1:0] r_tx_data;
    logic [WIDTH_DATA-1:0] w_rd_data;
    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_tx_we;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_DEPTH);
    assign o_count   = r_count;
    assign o_tx_data = r_tx_data;
    assign o_tx_we   = w_tx_we;

    // A pop frees a slot in the same cycle, so a push at full is still taken.
    assign w_pop  = (r_state == ST_IDLE) && !o_empty && i_tx_mty;
    assign w_push = i_we && (!o_full || w_pop);

    tx_fifo_mem #(
        .WIDTH_DATA (WIDTH_DATA),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tx_data <= '1;
            r_state   <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= w_rd_data;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // BUSY waits for the transmitter to take the strobe; HOLD waits for it to
    // latch the word at start-of-frame before another word may be offered.
    always_comb begin
        w_state_next = r_state;
        w_tx_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_tx_we      = 1'b1;
                w_state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (!i_tx_mty) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_tx_mty) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef TX_FIFO_OVF_EN
    logic r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (i_we && !w_push) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo.sv
`default_nettype none
// =============================================================================
// tb_tx_fifo : randomized and directed bench for tx_fifo against a queue model
// Rev 1.0
// =============================================================================
module tb_tx_fifo;

    localparam int DEPTH = 16;

    // Phases of one outstanding word in the transmitter handshake
    localparam int HS_READY     = 0;
    localparam int HS_STROBE    = 1;
    localparam int HS_WAIT_LOW  = 2;
    localparam int HS_WAIT_HIGH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we  = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx_mty = 1'b1;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       tx_we;
    logic [7:0] tx_data;
`ifdef TX_FIFO_OVF_EN
    logic       ovf;
    logic       exp_ovf;
`endif

    always #5 clk = ~clk;

    tx_fifo dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (we),
        .i_data    (data),
        .o_full    (full),
        .o_empty   (empty),
        .o_count   (count),
        .i_tx_mty  (tx_mty),
        .o_tx_we   (tx_we),
        .o_tx_data (tx_data)
`ifdef TX_FIFO_OVF_EN
        ,
        .o_ovf     (ovf)
`endif
    );

    // Reference model state
    logic [7:0] q[$];
    int         hs;
    logic [7:0] exp_data;
    logic       exp_we;

    // Transmitter model state
    bit         tx_block;
    bit         tx_mty_model;
    bit         tx_pending;
    int         tx_low_cnt;
    int         tx_low_len;

    logic [7:0] rx_log[$];
    int         n_strobes;
    int         n_tests;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic void apply_mty();
        tx_mty = tx_block ? 1'b0 : tx_mty_model;
    endfunction

    task automatic step();
        bit pop;
        bit push_ok;
        @(negedge clk);
        if (rst) begin
            q.delete();
            hs       = HS_READY;
            exp_data = 8'hFF;
            exp_we   = 1'b0;
`ifdef TX_FIFO_OVF_EN
            exp_ovf  = 1'b0;
`endif
        end else begin
            pop     = (hs == HS_READY) && (q.size() != 0) && tx_mty;
            push_ok = we && ((q.size() < DEPTH) || pop);
`ifdef TX_FIFO_OVF_EN
            if (we && !push_ok) exp_ovf = 1'b1;
`endif
            case (hs)
                HS_READY:     if (pop) hs = HS_STROBE;
                HS_STROBE:    hs = HS_WAIT_LOW;
                HS_WAIT_LOW:  if (!tx_mty) hs = HS_WAIT_HIGH;
                default:      if (tx_mty) hs = HS_READY;
            endcase
            if (pop) exp_data = q.pop_front();
            if (push_ok) q.push_back(data);
            exp_we = pop;
        end
        check("tx_we", {31'd0, tx_we}, {31'd0, exp_we});
        check("tx_data", {24'd0, tx_data}, {24'd0, exp_data});
        check("count", {27'd0, count}, 32'(q.size()));
        check("empty", {31'd0, empty}, {31'd0, q.size() == 0});
        check("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
`ifdef TX_FIFO_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
        if (tx_we === 1'b1) begin
            n_strobes++;
            rx_log.push_back(tx_data);
        end
        // Holding-empty falls the cycle after the strobe and rises when the
        // shifter loads the word tx_low_len cycles later.
        if (tx_we === 1'b1) begin
            tx_pending = 1'b1;
        end else if (tx_pending) begin
            tx_pending   = 1'b0;
            tx_mty_model = 1'b0;
            tx_low_cnt   = tx_low_len;
        end else if (!tx_mty_model) begin
            if (tx_low_cnt > 0) tx_low_cnt--;
            else tx_mty_model = 1'b1;
        end
        apply_mty();
    endtask

    task automatic push(input logic [7:0] d);
        we   = 1'b1;
        data = d;
        step();
        we   = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            step();
            done = (q.size() == 0) && (hs == HS_READY);
        end
        check("drain_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int strobes_before;
        int accepted;
        bit found;
        n_tests = 0;
        n_fail  = 0;
        n_strobes = 0;
        tx_block = 1'b0;
        tx_mty_model = 1'b1;
        tx_pending = 1'b0;
        tx_low_cnt = 0;
        tx_low_len = 10;
        hs = HS_READY;
        exp_data = 8'hFF;
        exp_we = 1'b0;
`ifdef TX_FIFO_OVF_EN
        exp_ovf = 1'b0;
`endif

        // Reset then idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        check("idle_count", {27'd0, count}, 32'd0);
        check("idle_data", {24'd0, tx_data}, 32'hFF);

        // Single word
        strobes_before = n_strobes;
        rx_log.delete();
        push(8'hA5);
        repeat (30) step();
        check("single_strobes", 32'(n_strobes - strobes_before), 32'd1);
        check("single_word", {24'd0, rx_log[0]}, 32'hA5);
        check("single_hold", {24'd0, tx_data}, 32'hA5);
        check("single_count", {27'd0, count}, 32'd0);

        // Burst ordering
        tx_low_len = 3;
        rx_log.delete();
        for (int i = 1; i <= 5; i++) push(8'(i));
        drain();
        check("burst_len", 32'(rx_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_log.size(); i++)
            check("burst_word", {24'd0, rx_log[i]}, 32'(i + 1));

        // Full and drop
        rx_log.delete();
        tx_block = 1'b1;
        apply_mty();
        for (int i = 0; i <= 16; i++) begin
            push(8'(i));
            if (i == 15) check("full_at_16", {31'd0, full}, 32'd1);
        end
        check("full_count", {27'd0, count}, 32'd16);
`ifdef TX_FIFO_OVF_EN
        check("ovf_set", {31'd0, ovf}, 32'd1);
`endif
        tx_block = 1'b0;
        apply_mty();
        drain();
        check("drop_len", 32'(rx_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx_log.size(); i++)
            check("drop_word", {24'd0, rx_log[i]}, 32'(i));

        // Simultaneous push/pop at full, then wrap
        rx_log.delete();
        tx_block = 1'b1;
        apply_mty();
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        tx_block = 1'b0;
        apply_mty();
        push(8'h80);
        check("simul_count", {27'd0, count}, 32'd16);
        check("simul_pop", {31'd0, tx_we}, 32'd1);
        accepted = 0;
        for (int i = 0; i < 3000 && accepted < 40; i++) begin
            if (q.size() < DEPTH) begin
                push(8'(8'h81 + accepted));
                accepted++;
            end else begin
                step();
            end
        end
        drain();
        check("wrap_len", 32'(rx_log.size()), 32'd57);
        for (int i = 0; i < 57 && i < rx_log.size(); i++)
            check("wrap_word", {24'd0, rx_log[i]}, (i < 16) ? 32'(8'h40 + i) : 32'(8'h80 + (i - 16)));

        // Reset mid-operation while holding with 3 queued
        tx_low_len = 20;
        for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            found = (hs == HS_WAIT_HIGH) && (q.size() == 3);
            if (!found) step();
        end
        check("rst_reach_hold", {31'd0, found}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_we", {31'd0, tx_we}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'hFF);
        strobes_before = n_strobes;
        repeat (40) step();
        check("rst_no_strobe", 32'(n_strobes - strobes_before), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            tx_low_len = int'($urandom_range(0, 5));
            we   = ($urandom_range(0, 2) != 0);
            data = 8'($urandom);
            step();
        end
        we = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
